// File: rtl/risc16_uart_tx.sv
// Memory-mapped UART transmitter for the Risc_16_bit CPU.
// CPU stores to TX_ADDR queue a byte in a small FIFO; a serializer drains
// the FIFO as 8N1 frames (start, 8 data bits LSB first, stop) on tx.
// Stores to STAT_ADDR clear the sticky overflow flag.
module risc16_uart_tx #(
    parameter logic [15:0] TX_ADDR      = 16'hFF00,
    parameter logic [15:0] STAT_ADDR    = 16'hFF01,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow
);

    // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally.
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_TICK = BCNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [BCNT_W-1:0] bit_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic              overflow_reg;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic push_req;
    logic push_ok;
    logic stat_clr;
    logic pop;
    logic fifo_full;
    logic unused_hi;

    // Upper data byte of the store bus carries nothing for this peripheral.
    assign unused_hi = ^mem_wdata[15:8];

    assign fifo_full = (count_reg == DEPTH_C);
    assign push_req  = mem_wr && (mem_addr == TX_ADDR);
    assign stat_clr  = mem_wr && (mem_addr == STAT_ADDR);

    // The serializer takes a byte when idle, or at the last tick of a stop
    // bit so that queued frames follow each other with no gap.
    assign pop = (count_reg != '0) &&
                 ((state_reg == IDLE) ||
                  ((state_reg == STOP) && (bit_cnt_reg == LAST_TICK)));

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok = push_req && (!fifo_full || pop);

    // Occupancy update for simultaneous push/pop.
    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // FIFO storage: write-only array, read is registered by the serializer.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            fifo_mem[wr_ptr_reg] <= mem_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            // A dropped byte outranks a simultaneous clear.
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end else if (stat_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Serializer FSM: tx is registered and updated together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg      <= 1'b1;
                    bit_cnt_reg <= '0;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr_reg];
                        state_reg <= START;
                        tx_reg    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_cnt_reg == LAST_TICK) begin
                        bit_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BCNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt_reg == LAST_TICK) begin
                        bit_cnt_reg <= '0;
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BCNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt_reg == LAST_TICK) begin
                        bit_cnt_reg <= '0;
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr_reg];
                            state_reg <= START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BCNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_reg;
    assign busy     = (state_reg != IDLE) || (count_reg != '0);
    assign full     = fifo_full;
    assign overflow = overflow_reg;

endmodule
